fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the RISC-V core. It holds the program counter and drives the word address into the instruction memory `mem_instr`, whose read is combinational. It captures the returned word into an IF/ID pipeline register for the decoder. It also handles stall, redirect (branch/jump) with flush, and keeps a fetched-instruction counter.

## Interface
Parameters:
- ADDR_W, 5, word-address width into `mem_instr` (memory depth 2^ADDR_W words)
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset; synchronous, active-high
- stall  input  1  hold PC and IF/ID contents
- redirect  input  1  take `redirect_pc` next cycle and flush IF/ID
- redirect_pc  input  32  branch/jump target byte address
- im_address  output  ADDR_W  word address to `mem_instr`; equals pc[ADDR_W+1:2]
- im_rd  input  32  instruction word from `mem_instr` (combinational, same cycle)
- pc  output  32  current fetch PC (registered)
- id_instr  output  32  instruction latched for decode
- id_pc  output  32  PC of `id_instr`
- id_valid  output  1  `id_instr` is a real fetched instruction
- fetch_count  output  32  number of instructions latched with `id_valid`=1
- misalign  output  1  sticky misaligned-redirect flag (only with FETCH_MISALIGN_CHK_EN)

## Operation
- Reset values (rst=1 at a rising edge): pc=RESET_PC, id_instr=32'h0000_0013 (NOP, addi x0,x0,0), id_pc=0, id_valid=0, fetch_count=0, misalign=0.
- `rst` has priority over every other input. Reset mid-operation discards any in-flight redirect or stall.
- PC update at each edge, in priority order:
  - redirect=1: pc <= {redirect_pc[31:2],2'b00}
  - else stall=1: pc holds
  - else: pc <= pc+4, modulo 2^32
- IF/ID update at each edge, in priority order:
  - redirect=1: id_valid<=0, id_instr<=NOP, id_pc holds. This is a flush of the wrong-path word.
  - else stall=1: id_instr, id_pc and id_valid hold.
  - else: id_instr<=im_rd, id_pc<=pc, id_valid<=1.
- redirect overrides stall when both are high in the same cycle.
- fetch_count increments by 1 on every edge where IF/ID loads with id_valid<=1. It wraps from 32'hFFFF_FFFF to 0 and never saturates.
- `im_address` is pure slicing of pc. Once pc exceeds the memory range, the address wraps: pc=0x7C gives address 31, then pc=0x80 gives address 0 (ADDR_W=5). This wrap is not flagged.

## Timing
- Fetch latency: 1 cycle. The word at address pc appears on `id_instr` after the next edge.
- After reset release, pc=RESET_PC in the first cycle. id_valid rises after the first non-stalled edge.
- Redirect penalty: 1 bubble.
  - Edge N samples redirect, giving pc=target and id_valid=0.
  - Edge N+1 latches the target instruction with id_valid=1.
- Stall has no limit on length. Outputs are bit-stable for its whole duration.

## Configuration
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - `misalign` port exists.
  - On any edge with redirect=1 and redirect_pc[1:0]!=0, `misalign` sets to 1 and stays set until rst.
  - The redirect is still taken with the low bits cleared.
- Undefined:
  - No `misalign` port and no flag logic.
  - redirect_pc[1:0] is silently ignored (forced to 00).

## Test plan
- Reset/sequential fetch: IM[0..2]=01234567, 01234333, 01234569; rst for 2 edges, then free-run 3 edges -> id_instr=01234567/01234333/01234569 with id_pc=0/4/8, id_valid=1, fetch_count=3, pc=0x0C.
- Stall: stall=1 for 3 edges after the first fetch -> pc, id_instr=01234567, id_pc=0 and fetch_count=1 all unchanged; on release the next edge gives id_instr=01234333.
- Redirect: at pc=0x08 assert redirect with redirect_pc=0x00000040 -> next edge pc=0x40, id_valid=0, id_instr=00000013; following edge id_instr=IM[16], id_pc=0x40, id_valid=1.
- Redirect+stall together: both high -> redirect wins (pc=target, id_valid=0); fetch_count unchanged.
- Wrap: redirect to 0x7C (ADDR_W=5), free-run -> im_address 31 then 0, id_pc=0x7C then 0x80.
- Macro on: redirect_pc=0x00000042 -> pc=0x40, misalign=1, still 1 after 5 more edges; rst clears it to 0. With the macro off, the same stimulus gives pc=0x40 and no flag.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, stall/redirect handling, fetch counter.
// Optional misaligned-redirect flag enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] im_address,
  input  logic [31:0]       im_rd,
  output logic [31:0]       pc,
  output logic [31:0]       id_instr,
  output logic [31:0]       id_pc,
  output logic              id_valid,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic              misalign,
`endif
  output logic [31:0]       fetch_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pc_next;
  logic        load_id;

  assign im_address = pc[ADDR_W+1:2];

  // Redirect outranks stall; a flushed slot never counts as a fetch.
  always_comb begin
    pc_next = pc + 32'd4;
    load_id = 1'b0;
    if (redirect) begin
      pc_next = {redirect_pc[31:2], 2'b00};
    end else if (stall) begin
      pc_next = pc;
    end else begin
      load_id = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      id_instr    <= NOP;
      id_pc       <= '0;
      id_valid    <= 1'b0;
      fetch_count <= '0;
    end else begin
      pc <= pc_next;
      if (redirect) begin
        id_instr <= NOP;
        id_valid <= 1'b0;
      end else if (load_id) begin
        id_instr    <= im_rd;
        id_pc       <= pc;
        id_valid    <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      misalign <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a combinational instruction-memory model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic [4:0]  im_address;
  logic [31:0] im_rd, pc, id_instr, id_pc, fetch_count;
  logic        id_valid;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign;
`endif

  logic [31:0] imem [32];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;
  assign im_rd = imem[im_address];

  fetch_unit #(.ADDR_W(5), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .im_address(im_address), .im_rd(im_rd), .pc(pc), .id_instr(id_instr), .id_pc(id_pc),
    .id_valid(id_valid),
`ifdef FETCH_MISALIGN_CHK_EN
    .misalign(misalign),
`endif
    .fetch_count(fetch_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pc !== 32'h0) $display("FAIL reset_pc got %h exp %h", pc, 32'h0); else passed++;
    total++; if (id_instr !== 32'h13) $display("FAIL reset_instr got %h exp %h", id_instr, 32'h13); else passed++;
    total++; if (id_pc !== 32'h0) $display("FAIL reset_id_pc got %h exp 0", id_pc); else passed++;
    total++; if (id_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", id_valid); else passed++;
    total++; if (fetch_count !== 32'h0) $display("FAIL reset_count got %0d exp 0", fetch_count); else passed++;
    total++; if (im_address !== 5'd0) $display("FAIL reset_addr got %0d exp 0", im_address); else passed++;
  endtask

  task automatic test_sequential();
    step();
    total++; if (id_instr !== 32'h01234567) $display("FAIL seq0_instr got %h exp 01234567", id_instr); else passed++;
    total++; if (id_pc !== 32'h0) $display("FAIL seq0_pc got %h exp 0", id_pc); else passed++;
    total++; if (id_valid !== 1'b1) $display("FAIL seq0_valid got %b exp 1", id_valid); else passed++;
    step();
    total++; if (id_instr !== 32'h01234333) $display("FAIL seq1_instr got %h exp 01234333", id_instr); else passed++;
    total++; if (id_pc !== 32'h4) $display("FAIL seq1_pc got %h exp 4", id_pc); else passed++;
    step();
    total++; if (id_instr !== 32'h01234569) $display("FAIL seq2_instr got %h exp 01234569", id_instr); else passed++;
    total++; if (id_pc !== 32'h8) $display("FAIL seq2_pc got %h exp 8", id_pc); else passed++;
    total++; if (fetch_count !== 32'd3) $display("FAIL seq_count got %0d exp 3", fetch_count); else passed++;
    total++; if (pc !== 32'hC) $display("FAIL seq_pcreg got %h exp c", pc); else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (pc !== 32'h4) $display("FAIL stall_pc[%0d] got %h exp 4", i, pc); else passed++;
      total++; if (id_instr !== 32'h01234567) $display("FAIL stall_instr[%0d] got %h exp 01234567", i, id_instr); else passed++;
      total++; if (id_pc !== 32'h0) $display("FAIL stall_idpc[%0d] got %h exp 0", i, id_pc); else passed++;
      total++; if (fetch_count !== 32'd1) $display("FAIL stall_count[%0d] got %0d exp 1", i, fetch_count); else passed++;
      total++; if (id_valid !== 1'b1) $display("FAIL stall_valid[%0d] got %b exp 1", i, id_valid); else passed++;
    end
    stall = 1'b0;
    step();
    total++; if (id_instr !== 32'h01234333) $display("FAIL unstall_instr got %h exp 01234333", id_instr); else passed++;
    total++; if (fetch_count !== 32'd2) $display("FAIL unstall_count got %0d exp 2", fetch_count); else passed++;
    total++; if (pc !== 32'h8) $display("FAIL unstall_pc got %h exp 8", pc); else passed++;
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    step();
    redirect = 1'b0;
    total++; if (pc !== 32'h40) $display("FAIL redir_pc got %h exp 40", pc); else passed++;
    total++; if (id_valid !== 1'b0) $display("FAIL redir_valid got %b exp 0", id_valid); else passed++;
    total++; if (id_instr !== 32'h13) $display("FAIL redir_instr got %h exp 13", id_instr); else passed++;
    total++; if (id_pc !== 32'h4) $display("FAIL redir_idpc_hold got %h exp 4", id_pc); else passed++;
    total++; if (fetch_count !== 32'd2) $display("FAIL redir_count got %0d exp 2", fetch_count); else passed++;
    step();
    total++; if (id_instr !== 32'hA000_0010) $display("FAIL redir_tgt_instr got %h exp a0000010", id_instr); else passed++;
    total++; if (id_pc !== 32'h40) $display("FAIL redir_tgt_pc got %h exp 40", id_pc); else passed++;
    total++; if (id_valid !== 1'b1) $display("FAIL redir_tgt_valid got %b exp 1", id_valid); else passed++;
    total++; if (fetch_count !== 32'd3) $display("FAIL redir_tgt_count got %0d exp 3", fetch_count); else passed++;
  endtask

  task automatic test_redirect_stall();
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_0020;
    step();
    redirect = 1'b0; stall = 1'b0;
    total++; if (pc !== 32'h20) $display("FAIL rs_pc got %h exp 20", pc); else passed++;
    total++; if (id_valid !== 1'b0) $display("FAIL rs_valid got %b exp 0", id_valid); else passed++;
    total++; if (fetch_count !== 32'd3) $display("FAIL rs_count got %0d exp 3", fetch_count); else passed++;
    step();
    total++; if (id_instr !== 32'hA000_0008) $display("FAIL rs_next_instr got %h exp a0000008", id_instr); else passed++;
    total++; if (fetch_count !== 32'd4) $display("FAIL rs_next_count got %0d exp 4", fetch_count); else passed++;
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'h0000_007C;
    step();
    redirect = 1'b0;
    total++; if (im_address !== 5'd31) $display("FAIL wrap_addr31 got %0d exp 31", im_address); else passed++;
    step();
    total++; if (im_address !== 5'd0) $display("FAIL wrap_addr0 got %0d exp 0", im_address); else passed++;
    total++; if (pc !== 32'h80) $display("FAIL wrap_pc got %h exp 80", pc); else passed++;
    total++; if (id_pc !== 32'h7C) $display("FAIL wrap_idpc7c got %h exp 7c", id_pc); else passed++;
    total++; if (id_instr !== 32'hA000_001F) $display("FAIL wrap_instr31 got %h exp a000001f", id_instr); else passed++;
    step();
    total++; if (id_pc !== 32'h80) $display("FAIL wrap_idpc80 got %h exp 80", id_pc); else passed++;
    total++; if (id_instr !== 32'h01234567) $display("FAIL wrap_instr0 got %h exp 01234567", id_instr); else passed++;
  endtask

  task automatic test_misalign();
    redirect = 1'b1; redirect_pc = 32'h0000_0042;
    step();
    redirect = 1'b0;
    total++; if (pc !== 32'h40) $display("FAIL mis_pc got %h exp 40", pc); else passed++;
`ifdef FETCH_MISALIGN_CHK_EN
    total++; if (misalign !== 1'b1) $display("FAIL mis_set got %b exp 1", misalign); else passed++;
    for (int i = 0; i < 5; i++) step();
    total++; if (misalign !== 1'b1) $display("FAIL mis_sticky got %b exp 1", misalign); else passed++;
`endif
    // reset wins over a concurrent redirect and stall
    rst = 1'b1; redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_0060;
    step();
    rst = 1'b0; redirect = 1'b0; stall = 1'b0;
    total++; if (pc !== 32'h0) $display("FAIL rst_prio_pc got %h exp 0", pc); else passed++;
    total++; if (fetch_count !== 32'd0) $display("FAIL rst_prio_count got %0d exp 0", fetch_count); else passed++;
`ifdef FETCH_MISALIGN_CHK_EN
    total++; if (misalign !== 1'b0) $display("FAIL mis_clear got %b exp 0", misalign); else passed++;
`endif
  endtask

  initial begin
    for (int i = 0; i < 32; i++) imem[i] = 32'hA000_0000 | i;
    imem[0] = 32'h01234567;
    imem[1] = 32'h01234333;
    imem[2] = 32'h01234569;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_misalign();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
